// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and small decode helpers for the fetch stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] IFUN_NONE = 4'h0;
  localparam logic [3:0] RNONE     = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Instruction length in bytes; undefined opcodes occupy a single byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                  instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      instr_len = 4'd2;
      I_JXX, I_CALL:                         instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          instr_len = 4'd10;
      default:                               instr_len = 4'd1;
    endcase
  endfunction

  // Opcodes followed by a register-specifier byte.
  function automatic logic has_regs(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:                has_regs = 1'b1;
      default:                               has_regs = 1'b0;
    endcase
  endfunction

  // Opcodes whose constant starts right after the opcode byte.
  function automatic logic valc_at1(input logic [3:0] icode);
    valc_at1 = (icode == I_JXX) || (icode == I_CALL);
  endfunction

  // Opcodes whose constant follows the register byte.
  function automatic logic valc_at2(input logic [3:0] icode);
    valc_at2 = (icode == I_IRMOVQ) || (icode == I_RMMOVQ) || (icode == I_MRMOVQ);
  endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte queue between the imem beat port and the instruction splitter.
// Accepts a beat with a leading-byte skip, pops whole instructions, and
// exposes a 10-byte window starting at the head.
module fetch_byte_queue #(
  parameter int BUF_BYTES   = 16,
  parameter int FETCH_BYTES = 8,
  localparam int PW = $clog2(BUF_BYTES),
  localparam int CW = PW + 1,
  localparam int SW = $clog2(FETCH_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [8*FETCH_BYTES-1:0] push_data_i,
  input  logic [SW-1:0]            push_skip_i,
  input  logic                     pop_i,
  input  logic [3:0]               pop_n_i,
  output logic [79:0]              head_o,
  output logic [CW-1:0]            count_o
);

  logic [7:0]    mem_q [BUF_BYTES];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] push_n, pop_n;

  // Number of bytes entering and leaving this cycle.
  always_comb begin
    push_n = push_i ? (CW'(FETCH_BYTES) - CW'(push_skip_i)) : '0;
    pop_n  = pop_i  ? CW'(pop_n_i) : '0;
  end

  // Byte storage: kept bytes of the beat are packed from the write pointer.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        if (SW'(i) >= push_skip_i)
          mem_q[wr_ptr_q + PW'(i) - PW'(push_skip_i)] <= push_data_i[8*i +: 8];
      end
    end
  end

  // Pointers and occupancy; clear wins over a simultaneous push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop_n);
      wr_ptr_q <= wr_ptr_q + PW'(push_n);
      count_q  <= count_q + push_n - pop_n;
    end
  end

  // Head window; bytes beyond count_o are stale and must be qualified by count.
  always_comb begin
    head_o = '0;
    for (int i = 0; i < 10; i++)
      head_o[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Y86-64 fetch stage: prefetches imem beats into a byte queue, splits the head
// instruction into fields, predicts the next PC and hands one instruction per
// cycle to decode. Redirects flush everything; HLT/INS/ADR stop fetching.
module fetch_prefetch_stage
  import y86_pkg::*;
#(
  parameter int                WORD_W      = 64,
  parameter int                FETCH_BYTES = 8,
  parameter int                BUF_BYTES   = 16,
  parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  output logic [WORD_W-1:0]        imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [8*FETCH_BYTES-1:0] imem_rsp_data,
  input  logic                     imem_rsp_err,
  input  logic                     redir_valid,
  input  logic [WORD_W-1:0]        redir_pc,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [2:0]               d_stat,
  output logic [3:0]               d_icode,
  output logic [3:0]               d_ifun,
  output logic [3:0]               d_rA,
  output logic [3:0]               d_rB,
  output logic [WORD_W-1:0]        d_valC,
  output logic [WORD_W-1:0]        d_pc,
  output logic [WORD_W-1:0]        d_valP,
  output logic [WORD_W-1:0]        pred_pc
);

  localparam int SW = $clog2(FETCH_BYTES);
  localparam int CW = $clog2(BUF_BYTES) + 1;
  localparam logic [WORD_W-1:0] BEAT_MASK  = ~WORD_W'(FETCH_BYTES - 1);
  localparam logic [WORD_W-1:0] RESET_BEAT = RESET_PC & BEAT_MASK;
  localparam logic [SW-1:0]     RESET_SKIP = RESET_PC[SW-1:0];

  localparam logic [0:0] REQ_IDLE   = 1'b0;
  localparam logic [0:0] REQ_WAIT   = 1'b1;
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HALTED  = 1'b1;

  logic [0:0]        req_state_q, req_state_d;
  logic [0:0]        run_state_q, run_state_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
  logic [SW-1:0]     skip_q, skip_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] pc_q, pc_d;

  logic [79:0]       head;
  logic [CW-1:0]     count;
  logic              q_push, q_pop;

  logic [3:0]        icode, ifun, len, rA, rB;
  logic              have, adr, emit_v, fire, req_fire, rsp_take;
  logic [2:0]        stat;
  logic [WORD_W-1:0] valC, valP, pred;

  fetch_byte_queue #(
    .BUF_BYTES  (BUF_BYTES),
    .FETCH_BYTES(FETCH_BYTES)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (redir_valid),
    .push_i     (q_push),
    .push_data_i(imem_rsp_data),
    .push_skip_i(skip_q),
    .pop_i      (q_pop),
    .pop_n_i    (len),
    .head_o     (head),
    .count_o    (count)
  );

  // Split the head instruction and decide whether it can be emitted.
  always_comb begin
    icode  = head[7:4];
    ifun   = head[3:0];
    len    = instr_len(icode);
    have   = count >= CW'(len);
    adr    = err_q && !have;
    emit_v = (run_state_q == ST_RUN) && (have || err_q);
    rA     = RNONE;
    rB     = RNONE;
    valC   = '0;
    if (adr) begin
      stat = STAT_ADR;
      if (count == '0) begin
        icode = I_HALT;
        ifun  = IFUN_NONE;
      end
    end else if (icode > I_POPQ) begin
      stat = STAT_INS;
    end else if (icode == I_HALT) begin
      stat = STAT_HLT;
    end else begin
      stat = STAT_AOK;
    end
    if (!adr && has_regs(icode)) begin
      rA = (icode == I_IRMOVQ) ? RNONE : head[15:12];
      rB = head[11:8];
    end
    if (!adr && valc_at1(icode))
      valC = WORD_W'(head[71:8]);
    else if (!adr && valc_at2(icode))
      valC = WORD_W'(head[79:16]);
    valP = adr ? pc_q : (pc_q + WORD_W'(len));
    pred = (!adr && valc_at1(icode)) ? valC : valP;
  end

  // Decode-side outputs read as all-zero whenever nothing is offered.
  always_comb begin
    d_valid = emit_v;
    d_stat  = '0;
    d_icode = '0;
    d_ifun  = '0;
    d_rA    = '0;
    d_rB    = '0;
    d_valC  = '0;
    d_pc    = '0;
    d_valP  = '0;
    pred_pc = '0;
    if (emit_v) begin
      d_stat  = stat;
      d_icode = icode;
      d_ifun  = ifun;
      d_rA    = rA;
      d_rB    = rB;
      d_valC  = valC;
      d_pc    = pc_q;
      d_valP  = valP;
      pred_pc = pred;
    end
  end

  // Handshakes: request only from IDLE with room for a whole beat.
  always_comb begin
    imem_req_valid = (req_state_q == REQ_IDLE) && (run_state_q == ST_RUN) && !err_q &&
                     ((CW'(BUF_BYTES) - count) >= CW'(FETCH_BYTES));
    imem_req_addr  = req_addr_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = (req_state_q == REQ_WAIT) && imem_rsp_valid;
    fire           = emit_v && d_ready && !redir_valid;
    q_push         = rsp_take && !drop_q && !redir_valid && !imem_rsp_err;
    q_pop          = fire && (stat != STAT_ADR);
  end

  // Next-state for request FSM, flags and PC; redirect overrides everything.
  always_comb begin
    req_state_d = req_state_q;
    run_state_d = run_state_q;
    drop_d      = drop_q;
    err_d       = err_q;
    skip_d      = skip_q;
    req_addr_d  = req_addr_q;
    pc_d        = pc_q;

    if (req_state_q == REQ_IDLE) begin
      if (req_fire) begin
        req_state_d = REQ_WAIT;
        req_addr_d  = req_addr_q + WORD_W'(FETCH_BYTES);
      end
    end else if (imem_rsp_valid) begin
      req_state_d = REQ_IDLE;
      drop_d      = 1'b0;
    end

    if (rsp_take && !drop_q && imem_rsp_err)
      err_d = 1'b1;
    if (q_push)
      skip_d = '0;
    if (fire) begin
      pc_d = valP;
      if (stat != STAT_AOK)
        run_state_d = ST_HALTED;
    end

    if (redir_valid) begin
      pc_d        = redir_pc;
      req_addr_d  = redir_pc & BEAT_MASK;
      skip_d      = redir_pc[SW-1:0];
      err_d       = 1'b0;
      run_state_d = ST_RUN;
      // A beat still owed by imem belongs to the old stream and must be discarded.
      if (req_fire || ((req_state_q == REQ_WAIT) && !imem_rsp_valid)) begin
        req_state_d = REQ_WAIT;
        drop_d      = 1'b1;
      end else begin
        req_state_d = REQ_IDLE;
        drop_d      = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_state_q <= REQ_IDLE;
      run_state_q <= ST_RUN;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      skip_q      <= RESET_SKIP;
      req_addr_q  <= RESET_BEAT;
      pc_q        <= RESET_PC;
    end else begin
      req_state_q <= req_state_d;
      run_state_q <= run_state_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      skip_q      <= skip_d;
      req_addr_q  <= req_addr_d;
      pc_q        <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage with a byte-array imem model.
module tb_fetch_prefetch_stage;

  localparam int WORD_W = 64;
  localparam int FB     = 8;
  localparam int BUF    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [8*FB-1:0]   imem_rsp_data;
  logic              imem_rsp_err;
  logic              redir_valid;
  logic [WORD_W-1:0] redir_pc;
  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_stat;
  logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
  logic [WORD_W-1:0] d_valC, d_pc, d_valP, pred_pc;

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0]  imem [256];
  int          lat_extra = 0;
  logic [63:0] err_addr  = '1;
  int          req_cnt   = 0;
  logic [63:0] req_log [64];
  logic        pend = 1'b0;
  logic [63:0] pend_addr;
  int          pend_wait;
  logic        acc;
  logic [63:0] acc_addr;
  int          snap;

  always #5 clk = ~clk;

  fetch_prefetch_stage #(
    .WORD_W     (WORD_W),
    .FETCH_BYTES(FB),
    .BUF_BYTES  (BUF),
    .RESET_PC   (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .d_ready       (d_ready),
    .d_valid       (d_valid),
    .d_stat        (d_stat),
    .d_icode       (d_icode),
    .d_ifun        (d_ifun),
    .d_rA          (d_rA),
    .d_rB          (d_rB),
    .d_valC        (d_valC),
    .d_pc          (d_pc),
    .d_valP        (d_valP),
    .pred_pc       (pred_pc)
  );

  // imem model: one beat returned lat_extra cycles after the cycle following acceptance.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      acc      = imem_req_valid && imem_req_ready && rst;
      acc_addr = imem_req_addr;
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      if (acc) begin
        if (req_cnt < 64) req_log[req_cnt] = acc_addr;
        req_cnt   = req_cnt + 1;
        pend      = 1'b1;
        pend_addr = acc_addr;
        pend_wait = lat_extra;
      end
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_err   = (pend_addr == err_addr);
          for (int b = 0; b < FB; b++)
            imem_rsp_data[8*b +: 8] = imem[pend_addr[7:0] + 8'(b)];
          pend = 1'b0;
        end else begin
          pend_wait = pend_wait - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_emit(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!d_valid && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk({tag, ".vld"}, 64'(d_valid), 64'd1);
  endtask

  task automatic emit(input string tag, input logic [2:0] stat, input logic [3:0] icode,
                      input logic [63:0] pc);
    wait_emit(tag);
    chk({tag, ".stat"}, 64'(d_stat), 64'(stat));
    chk({tag, ".icode"}, 64'(d_icode), 64'(icode));
    chk({tag, ".pc"}, d_pc, pc);
  endtask

  task automatic accept();
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    d_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] pc);
    @(negedge clk);
    redir_valid = 1'b1;
    redir_pc    = pc;
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit %0d", $time, 100000);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    redir_valid    = 1'b0;
    redir_pc       = '0;
    d_ready        = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    // irmovq $10,%rdx ; nop ; halt
    imem[0] = 8'h30; imem[1] = 8'hF2; imem[2] = 8'h0A; imem[10] = 8'h10; imem[11] = 8'h00;
    imem[8'h10] = 8'hC0; imem[8'h11] = 8'hC0; imem[8'h12] = 8'hC0;
    imem[8'h13] = 8'h10; imem[8'h14] = 8'h00;

    // reset state
    idle(3);
    chk("rst.vld", 64'(d_valid), 64'd0);
    chk("rst.stat", 64'(d_stat), 64'd0);
    chk("rst.icode", 64'(d_icode), 64'd0);
    chk("rst.pc", d_pc, 64'd0);
    chk("rst.valC", d_valC, 64'd0);
    chk("rst.pred", pred_pc, 64'd0);
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b1;

    // irmovq then nop then halt from RESET_PC
    emit("irmovq", 3'd1, 4'h3, 64'h0);
    chk("irmovq.ifun", 64'(d_ifun), 64'h0);
    chk("irmovq.rA", 64'(d_rA), 64'hF);
    chk("irmovq.rB", 64'(d_rB), 64'h2);
    chk("irmovq.valC", d_valC, 64'd10);
    chk("irmovq.valP", d_valP, 64'hA);
    chk("irmovq.pred", pred_pc, 64'hA);
    accept();
    emit("nop", 3'd1, 4'h1, 64'hA);
    chk("nop.valP", d_valP, 64'hB);
    chk("nop.rA", 64'(d_rA), 64'hF);
    accept();
    emit("halt", 3'd2, 4'h0, 64'hB);
    accept();
    idle(4);
    snap = req_cnt;
    idle(6);
    chk("halt.vld", 64'(d_valid), 64'd0);
    chk("halt.noreq", 64'(req_cnt), 64'(snap));

    // redirect while a request is outstanding
    lat_extra = 3;
    snap = req_cnt;
    redirect(64'h20);
    begin
      int k;
      k = 0;
      while (req_cnt == snap && k < 20) begin
        @(negedge clk);
        k = k + 1;
      end
    end
    chk("r13.firstreq", req_log[snap], 64'h20);
    redirect(64'h13);
    lat_extra = 0;
    snap = req_cnt;
    emit("r13", 3'd1, 4'h1, 64'h13);
    chk("r13.reqaddr", req_log[snap], 64'h10);
    chk("r13.valP", d_valP, 64'h14);
    accept();
    emit("r13.halt", 3'd2, 4'h0, 64'h14);
    accept();
    idle(8);

    // jmp 0x40 at 0x5, then redirect racing a handshake
    imem[5] = 8'h70; imem[6] = 8'h40;
    for (int i = 7; i < 14; i++) imem[i] = 8'h00;
    imem[14] = 8'h10; imem[15] = 8'h00;
    redirect(64'h5);
    emit("jmp", 3'd1, 4'h7, 64'h5);
    chk("jmp.valC", d_valC, 64'h40);
    chk("jmp.pred", pred_pc, 64'h40);
    chk("jmp.valP", d_valP, 64'hE);
    chk("jmp.rB", 64'(d_rB), 64'hF);
    accept();
    wait_emit("race");
    chk("race.pc", d_pc, 64'hE);
    d_ready     = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 64'hE;
    @(posedge clk);
    #1;
    d_ready     = 1'b0;
    redir_valid = 1'b0;
    emit("race.after", 3'd1, 4'h1, 64'hE);
    accept();
    emit("race.halt", 3'd2, 4'h0, 64'hF);
    accept();
    idle(8);

    // stall with a full queue
    for (int i = 8'h60; i < 8'h80; i++) imem[i] = 8'h10;
    imem[8'h80] = 8'h00;
    redirect(64'h60);
    idle(20);
    snap = req_cnt;
    chk("stall.reqv", 64'(imem_req_valid), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall.vld", 64'(d_valid), 64'd1);
      chk("stall.pc", d_pc, 64'h60);
    end
    chk("stall.noreq", 64'(req_cnt), 64'(snap));
    for (int i = 0; i < 32; i++) begin
      emit("stream", 3'd1, 4'h1, 64'h60 + 64'(i));
      accept();
    end
    emit("stream.halt", 3'd2, 4'h0, 64'h80);
    accept();
    idle(8);

    // invalid opcode
    imem[8'hA0] = 8'hC0;
    redirect(64'hA0);
    emit("ins", 3'd4, 4'hC, 64'hA0);
    accept();
    idle(2);
    snap = req_cnt;
    idle(6);
    chk("ins.vld", 64'(d_valid), 64'd0);
    chk("ins.noreq", 64'(req_cnt), 64'(snap));
    chk("ins.reqv", 64'(imem_req_valid), 64'd0);

    // irmovq straddling into a faulting beat
    imem[8'hC4] = 8'h30; imem[8'hC5] = 8'hF3;
    err_addr = 64'hC8;
    redirect(64'hC4);
    emit("adr", 3'd3, 4'h3, 64'hC4);
    accept();
    idle(4);
    chk("adr.vld", 64'(d_valid), 64'd0);
    chk("adr.stat", 64'(d_stat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
